// File: rtl/tdm_mux8_tx.sv
// Eight-channel TDM transmitter: snapshots i1..i8 on a frame start and sends one bit per
// clock on y, tagged with its slot index on {s1,s2,s3}, optionally followed by GAP idle cycles.
module tdm_mux8_tx #(
   parameter int unsigned GAP = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4,
   input  logic i5,
   input  logic i6,
   input  logic i7,
   input  logic i8,
   input  logic start,
   input  logic cont,
   output logic y,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic valid,
   output logic frame,
   output logic done,
   output logic busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_CNT = 4'(GAP);

   state_t     state, state_nx;
   logic [2:0] slot, slot_nx;
   logic [7:0] snap, snap_nx;
   logic [3:0] cnt, cnt_nx;
   logic [7:0] in_bits;
   logic       send_nx;

   // i1 lands in bit 0 so that snap[slot] is the bit for that slot.
   assign in_bits = {i8, i7, i6, i5, i4, i3, i2, i1};

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_nx = state;
      slot_nx  = slot;
      snap_nx  = snap;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (start || cont) begin
               state_nx = S_SEND;
               slot_nx  = 3'd0;
               snap_nx  = in_bits;
            end
         end
         S_SEND: begin
            if (slot != 3'd7) begin
               slot_nx = slot + 3'd1;
            end else if (GAP_CNT != 4'd0) begin
               state_nx = S_GAP;
               cnt_nx   = GAP_CNT;
            end else if (cont) begin
               slot_nx = 3'd0;
               snap_nx = in_bits;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_GAP: begin
            cnt_nx = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               if (cont) begin
                  state_nx = S_SEND;
                  slot_nx  = 3'd0;
                  snap_nx  = in_bits;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign send_nx = (state_nx == S_SEND);

   // Outputs are registered from the next-state values so slot 0 appears right after the start edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state        <= S_IDLE;
         slot         <= 3'd0;
         snap         <= 8'd0;
         cnt          <= 4'd0;
         y            <= 1'b0;
         {s1, s2, s3} <= 3'd0;
         valid        <= 1'b0;
         frame        <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         slot         <= slot_nx;
         snap         <= snap_nx;
         cnt          <= cnt_nx;
         y            <= send_nx & snap_nx[slot_nx];
         {s1, s2, s3} <= send_nx ? slot_nx : 3'd0;
         valid        <= send_nx;
         frame        <= send_nx && (slot_nx == 3'd0);
         done         <= send_nx && (slot_nx == 3'd7);
         busy         <= (state_nx != S_IDLE);
      end
   end

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Scoreboard bench for tdm_mux8_tx: one instance with GAP=0 and one with GAP=3; expected
// per-cycle outputs are queued by the stimulus and consumed by a negedge monitor.
module tb_tdm_mux8_tx;

   typedef struct packed {
      logic       valid;
      logic       y;
      logic [2:0] slot;
      logic       frame;
      logic       done;
      logic       busy;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i0, i3;
   logic       start0, cont0, start3, cont3;
   obs_t       got0, got3;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;
   exp_t       q[2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tdm_mux8_tx #(.GAP(0)) dut0 (
      .clk(clk), .rst(rst),
      .i1(i0[0]), .i2(i0[1]), .i3(i0[2]), .i4(i0[3]),
      .i5(i0[4]), .i6(i0[5]), .i7(i0[6]), .i8(i0[7]),
      .start(start0), .cont(cont0),
      .y(got0.y), .s1(got0.slot[2]), .s2(got0.slot[1]), .s3(got0.slot[0]),
      .valid(got0.valid), .frame(got0.frame), .done(got0.done), .busy(got0.busy)
   );

   tdm_mux8_tx #(.GAP(3)) dut3 (
      .clk(clk), .rst(rst),
      .i1(i3[0]), .i2(i3[1]), .i3(i3[2]), .i4(i3[3]),
      .i5(i3[4]), .i6(i3[5]), .i7(i3[6]), .i8(i3[7]),
      .start(start3), .cont(cont3),
      .y(got3.y), .s1(got3.slot[2]), .s2(got3.slot[1]), .s3(got3.slot[0]),
      .valid(got3.valid), .frame(got3.frame), .done(got3.done), .busy(got3.busy)
   );

   task automatic check(input string name, input int which, input obs_t got,
                        input obs_t exp, input int ecyc);
      n_tests++;
      if (got !== exp || ecyc != cyc) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d: got v=%b y=%b s=%0d f=%b d=%b b=%b, required v=%b y=%b s=%0d f=%b d=%b b=%b at cyc %0d",
                  name, which, cyc, got.valid, got.y, got.slot, got.frame, got.done, got.busy,
                  exp.valid, exp.y, exp.slot, exp.frame, exp.done, exp.busy, ecyc);
      end
   endtask

   // Monitor: a busy cycle consumes the next expected entry; an idle cycle must be all zero.
   task automatic mon(input int which, input obs_t got);
      exp_t e;
      if (got.busy) begin
         if (q[which].size() == 0) begin
            check("unexpected_output", which, got, '0, -1);
         end else begin
            e = q[which].pop_front();
            check("slot", which, got, e.o, e.cyc);
         end
      end else if (q[which].size() != 0 && q[which][0].cyc <= cyc) begin
         e = q[which].pop_front();
         check("missing_output", which, got, e.o, e.cyc);
      end else begin
         check("idle", which, got, '0, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, got0);
         mon(1, got3);
      end
   end

   // Queue the expected frame whose capture edge is e (slot k shows after edge e+k).
   task automatic push_frame(input int which, input int e, input logic [7:0] bits,
                             input int gap, input int nslots);
      exp_t x;
      for (int k = 0; k < nslots; k++) begin
         x.cyc     = e + k;
         x.o.valid = 1'b1;
         x.o.y     = bits[k];
         x.o.slot  = 3'(k);
         x.o.frame = (k == 0);
         x.o.done  = (k == 7);
         x.o.busy  = 1'b1;
         q[which].push_back(x);
      end
      if (nslots == 8) begin
         for (int g = 0; g < gap; g++) begin
            x.cyc  = e + 8 + g;
            x.o    = '0;
            x.o.busy = 1'b1;
            q[which].push_back(x);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int e;
      rst = 1'b1; i0 = 8'hFF; i3 = 8'hFF;
      start0 = 1'b1; start3 = 1'b1; cont0 = 1'b0; cont3 = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0; start0 = 1'b0; start3 = 1'b0;
      repeat (4) tick();

      // Single frame, channels 1,0,1,1,0,0,1,0 -> 8'h4D; inputs toggle and start pulses during SEND.
      i0 = 8'h4D; start0 = 1'b1;
      e = cyc + 1;
      push_frame(0, e, 8'h4D, 0, 8);
      tick();
      for (int k = 0; k < 6; k++) begin
         i0 = ~i0;
         start0 = (k % 2 == 0);
         tick();
      end
      start0 = 1'b0;
      repeat (6) tick();

      // Continuous GAP=0: three back-to-back frames, cont dropped inside the third.
      i0 = 8'hA5; cont0 = 1'b1;
      e = cyc + 1;
      push_frame(0, e, 8'hA5, 0, 8);
      tick();
      i0 = 8'h3C;
      push_frame(0, e + 8, 8'h3C, 0, 8);
      wait_until(e + 8);
      i0 = 8'hF0;
      push_frame(0, e + 16, 8'hF0, 0, 8);
      wait_until(e + 18);
      cont0 = 1'b0;
      i0 = 8'h0F;
      wait_until(e + 28);

      // Continuous GAP=3: frame + 3 gap cycles, period 11; cont dropped in the second frame.
      i3 = 8'h96; cont3 = 1'b1;
      e = cyc + 1;
      push_frame(1, e, 8'h96, 3, 8);
      tick();
      i3 = 8'h5A;
      push_frame(1, e + 11, 8'h5A, 3, 8);
      wait_until(e + 13);
      cont3 = 1'b0;
      i3 = 8'hFF;
      wait_until(e + 26);

      // Reset while slot 4 is presented, then a fresh frame from a new snapshot.
      i3 = 8'hC3; cont3 = 1'b1;
      e = cyc + 1;
      push_frame(1, e, 8'hC3, 3, 5);
      wait_until(e + 4);
      rst = 1'b1; i3 = 8'h3E;
      tick();
      rst = 1'b0;
      push_frame(1, e + 6, 8'h3E, 3, 8);
      tick();
      cont3 = 1'b0; i3 = 8'h00;
      repeat (16) tick();

      mon_en = 1'b0;
      for (int w = 0; w < 2; w++) begin
         n_tests++;
         if (q[w].size() != 0) begin
            n_fail++;
            $display("FAIL drain dut%0d: %0d expected entries left, required 0", w, q[w].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_mux8_tx.md
# tdm_mux8_tx

Eight-channel time-division multiplexing transmitter: snapshots eight 1-bit inputs on a frame start and sends them one per clock onto a single serial line. Each bit goes out with its 3-bit slot select, so a downstream 1x8 demultiplexer can route every bit back to its channel. The block sits on the transmit side of the TDM link, between the parallel source logic and the serial line.

## Interface
- GAP, default 0: idle cycles inserted after every frame before the next frame may start (0..15).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i1..i8  in  1 each  channel inputs; i1 is slot 0, i8 is slot 7.
- start  in  1  single-frame request; sampled only when idle.
- cont  in  1  continuous mode; while high, frames repeat without start.
- y  out  1  serial data for the current slot.
- s1,s2,s3  out  1 each  slot select, s1 = MSB; {s1,s2,s3} = slot index.
- valid  out  1  y and s1..s3 carry a live slot.
- frame  out  1  pulse with slot 0 of every frame.
- done  out  1  pulse with slot 7 of every frame.
- busy  out  1  high from slot 0 through the last gap cycle.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 or cont=1 at an edge captures {i1..i8} into an 8-bit snapshot, sets slot=0 and enters SEND.
  - Otherwise the block stays in IDLE.
- SEND:
  - Per cycle: y=snapshot[slot], {s1,s2,s3}=slot, valid=1.
  - frame=1 when slot=0; done=1 when slot=7.
  - Slot increments each edge.
  - At the edge leaving slot 7:
    - If GAP>0, enter GAP with a counter loaded to GAP.
    - If GAP=0 and cont=1, recapture the snapshot and restart at slot 0 (back-to-back frames).
    - Otherwise return to IDLE.
- GAP:
  - Outputs as idle except busy=1.
  - Counter decrements each edge.
  - When it reaches 0, the next state follows the same rule: cont=1 starts a new frame (snapshot taken at that edge), else IDLE.
- start is ignored in SEND and GAP; there is no queueing.
- cont falling mid-frame: the current frame and its gap complete, then the block goes to IDLE.
- Inputs changing during SEND have no effect; only the snapshot is transmitted.
- Idle output values: y=0, s1..s3=000, valid=0, frame=0, done=0, busy=0.
- All outputs are registered.

## Timing
- Reset (rst=1 at an edge): state IDLE, slot 0, snapshot 0, counter 0; all outputs 0 after that edge.
- Reset mid-frame or mid-gap aborts immediately, with outputs 0 after the reset edge. No partial frame resumes.
- rst has priority over start and cont in the same cycle.
- Latency: with start high at edge N, slot 0 is presented in the cycle after edge N. Slot k is presented in the cycle after edge N+k; done is in the cycle after edge N+7.
- Frame length: 8 cycles of valid=1. Frame period in continuous mode is 8+GAP cycles.
- Slot index wraps 7 -> 0 only on a new frame, never within one.

## Test plan
- Reset: hold rst for 2 cycles with i=8'hFF and start=1 -> all outputs 0, busy=0; after release, no frame until the next start.
- Single frame, GAP=0: i1..i8=1,0,1,1,0,0,1,0, pulse start -> y sequence 1,0,1,1,0,0,1,0 with {s1,s2,s3}=000..111; valid for 8 cycles; frame in cycle 1, done in cycle 8; then IDLE.
- Snapshot hold: invert all inputs during SEND -> transmitted bits still match the captured pattern; start pulses during SEND are ignored.
- Continuous mode, GAP=0: cont=1 for 3 frames with inputs changed between frames -> 24 consecutive valid cycles, each frame carrying inputs as sampled at its slot-0 edge; dropping cont in frame 3 ends the stream after that frame's slot 7.
- GAP=3, cont=1: 8 valid cycles, 3 cycles with valid=0 and busy=1, repeating; the frame pulse recurs every 11 cycles.
- Reset at slot 4 -> outputs 0 on the next cycle; with cont=1 after release, a new frame starts at slot 0 from a fresh snapshot.
